// File: rtl/mod6_pkg.sv
// Shared definitions for the mod-6 sequence monitor: code width, terminal
// code, FSM state encoding and the successor/legality helpers.
package mod6_pkg;

    localparam int unsigned CODE_W = 4;
    localparam logic [CODE_W-1:0] MOD6_MAX = 4'd5;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } mon_state_e;

    // Successor of a legal mod-6 code: 0->1 ... 4->5, 5->0.
    function automatic logic [CODE_W-1:0] mod6_next(input logic [CODE_W-1:0] code);
        return (code == MOD6_MAX) ? '0 : code + 4'd1;
    endfunction

    // Legal codes are 0..MOD6_MAX (bit 3 is therefore always clear).
    function automatic logic mod6_legal(input logic [CODE_W-1:0] code);
        return (code <= MOD6_MAX);
    endfunction

endpackage

// File: rtl/mod6_step_check.sv
// Combinational classifier for one observed step prev_code -> count_in.
module mod6_step_check
    import mod6_pkg::*;
(
    input  logic [CODE_W-1:0] prev_code,
    input  logic [CODE_W-1:0] count_in,
    input  logic              prev_valid,
    output logic              step_valid,
    output logic              step_invalid,
    output logic              is_wrap
);

    // A step exists only once a previous code has been captured; it is valid
    // when the previous code is legal and the new code is its successor.
    always_comb begin
        step_valid   = 1'b0;
        step_invalid = 1'b0;
        is_wrap      = 1'b0;
        if (prev_valid) begin
            step_valid   = mod6_legal(prev_code) && (count_in == mod6_next(prev_code));
            step_invalid = !step_valid;
            is_wrap      = step_valid && (prev_code == MOD6_MAX);
        end
    end

endmodule

// File: rtl/mod6_sequence_monitor.sv
// Monitors a mod-6 counter code stream: locks after LOCK_THRESH consecutive
// valid steps, flags a fault when a locked stream breaks, counts wraps while
// locked and invalid steps overall.
module mod6_sequence_monitor
    import mod6_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 3,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        count_in,
    output logic              locked,
    output logic              fault,
    output logic              wrap_pulse,
    output logic [5:0]        phase,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [2:0] THRESH    = 3'(LOCK_THRESH);
    localparam logic [2:0] THRESH_M1 = 3'(LOCK_THRESH - 1);

    mon_state_e        state_q, state_d;
    logic [2:0]        good_cnt_q, good_cnt_d;
    logic [CODE_W-1:0] prev_code_q;
    logic              prev_valid_q;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              wrap_q, wrap_d;
    logic [5:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  err_q, err_d;

    logic step_valid;
    logic step_invalid;
    logic is_wrap;

    mod6_step_check u_step_check (
        .prev_code    (prev_code_q),
        .count_in     (count_in),
        .prev_valid   (prev_valid_q),
        .step_valid   (step_valid),
        .step_invalid (step_invalid),
        .is_wrap      (is_wrap)
    );

    // Next-state, streak counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;

        unique case (state_q)
            SEARCH: if (step_valid && (good_cnt_q == THRESH_M1)) state_d = LOCKED;
            LOCKED: if (step_invalid) state_d = FAULT;
            FAULT:  state_d = SEARCH;
            default: state_d = SEARCH;
        endcase

        // Steps seen while in FAULT never contribute to the next lock attempt.
        if (state_q == FAULT || step_invalid) begin
            good_cnt_d = '0;
        end else if (step_valid && (good_cnt_q != THRESH)) begin
            good_cnt_d = good_cnt_q + 3'd1;
        end

        locked_d = (state_d == LOCKED);
        fault_d  = (state_q == LOCKED) && step_invalid;
        wrap_d   = (state_q == LOCKED) && is_wrap;

        cycle_d = wrap_d ? (cycle_q + CNT_W'(1)) : cycle_q;
        err_d   = (step_invalid && (err_q != '1)) ? (err_q + CNT_W'(1)) : err_q;

        // Illegal codes match no bit, leaving phase all zeros.
        phase_d = '0;
        for (int unsigned n = 0; n < 6; n++) begin
            phase_d[n] = (count_in == CODE_W'(n));
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SEARCH;
            good_cnt_q   <= '0;
            prev_code_q  <= '0;
            prev_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            wrap_q       <= 1'b0;
            phase_q      <= '0;
            cycle_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            prev_code_q  <= count_in;
            prev_valid_q <= 1'b1;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            wrap_q       <= wrap_d;
            phase_q      <= phase_d;
            cycle_q      <= cycle_d;
            err_q        <= err_d;
        end
    end

    assign locked      = locked_q;
    assign fault       = fault_q;
    assign wrap_pulse  = wrap_q;
    assign phase       = phase_q;
    assign cycle_count = cycle_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_mod6_sequence_monitor.sv
// Directed, table-driven bench for mod6_sequence_monitor (LOCK_THRESH=3, CNT_W=8).
module tb_mod6_sequence_monitor;

    typedef struct {
        logic [3:0] code;
        logic       locked;
        logic       fault;
        logic       wrap;
        logic [5:0] phase;
        logic [7:0] cyc;
        logic [7:0] err;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic [3:0] count_in;
    logic       locked;
    logic       fault;
    logic       wrap_pulse;
    logic [5:0] phase;
    logic [7:0] cycle_count;
    logic [7:0] err_count;

    int unsigned n_vec;
    int unsigned n_bad;

    vec_t tbl[29];

    mod6_sequence_monitor #(
        .LOCK_THRESH (3),
        .CNT_W       (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .count_in    (count_in),
        .locked      (locked),
        .fault       (fault),
        .wrap_pulse  (wrap_pulse),
        .phase       (phase),
        .cycle_count (cycle_count),
        .err_count   (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input vec_t e);
        n_vec++;
        if (locked !== e.locked || fault !== e.fault || wrap_pulse !== e.wrap ||
            phase !== e.phase || cycle_count !== e.cyc || err_count !== e.err) begin
            n_bad++;
            $display("FAIL %s: got locked=%b fault=%b wrap=%b phase=%06b cyc=%0d err=%0d, want locked=%b fault=%b wrap=%b phase=%06b cyc=%0d err=%0d",
                     name, locked, fault, wrap_pulse, phase, cycle_count, err_count,
                     e.locked, e.fault, e.wrap, e.phase, e.cyc, e.err);
        end
    endtask

    // Upstream counter behaviour: new code on negedge, sampled on next posedge.
    task automatic step(input logic [3:0] code);
        @(negedge clock);
        reset_n  = 1'b1;
        count_in = code;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic l, input logic f,
                                input logic w, input logic [5:0] p,
                                input logic [7:0] cy, input logic [7:0] er);
        vec_t v;
        v.code = c; v.locked = l; v.fault = f; v.wrap = w;
        v.phase = p; v.cyc = cy; v.err = er;
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;

        //           code  lk f  w  phase       cyc err
        // lock-in: first edge evaluates no step, lock on 4th edge
        tbl[0]  = mk(4'd5, 0, 0, 0, 6'b100000, 0, 0);
        tbl[1]  = mk(4'd0, 0, 0, 0, 6'b000001, 0, 0);
        tbl[2]  = mk(4'd1, 0, 0, 0, 6'b000010, 0, 0);
        tbl[3]  = mk(4'd2, 1, 0, 0, 6'b000100, 0, 0);
        // locked run with two wraps
        tbl[4]  = mk(4'd3, 1, 0, 0, 6'b001000, 0, 0);
        tbl[5]  = mk(4'd4, 1, 0, 0, 6'b010000, 0, 0);
        tbl[6]  = mk(4'd5, 1, 0, 0, 6'b100000, 0, 0);
        tbl[7]  = mk(4'd0, 1, 0, 1, 6'b000001, 1, 0);
        tbl[8]  = mk(4'd1, 1, 0, 0, 6'b000010, 1, 0);
        tbl[9]  = mk(4'd2, 1, 0, 0, 6'b000100, 1, 0);
        tbl[10] = mk(4'd3, 1, 0, 0, 6'b001000, 1, 0);
        tbl[11] = mk(4'd4, 1, 0, 0, 6'b010000, 1, 0);
        tbl[12] = mk(4'd5, 1, 0, 0, 6'b100000, 1, 0);
        tbl[13] = mk(4'd0, 1, 0, 1, 6'b000001, 2, 0);
        // skip 3->5 while locked: fault pulse, then FAULT ignores 5->0
        tbl[14] = mk(4'd1, 1, 0, 0, 6'b000010, 2, 0);
        tbl[15] = mk(4'd2, 1, 0, 0, 6'b000100, 2, 0);
        tbl[16] = mk(4'd3, 1, 0, 0, 6'b001000, 2, 0);
        tbl[17] = mk(4'd5, 0, 1, 0, 6'b100000, 2, 1);
        tbl[18] = mk(4'd0, 0, 0, 0, 6'b000001, 2, 1);
        // relock after three further valid steps
        tbl[19] = mk(4'd1, 0, 0, 0, 6'b000010, 2, 1);
        tbl[20] = mk(4'd2, 0, 0, 0, 6'b000100, 2, 1);
        tbl[21] = mk(4'd3, 1, 0, 0, 6'b001000, 2, 1);
        tbl[22] = mk(4'd4, 1, 0, 0, 6'b010000, 2, 1);
        tbl[23] = mk(4'd5, 1, 0, 0, 6'b100000, 2, 1);
        // 5->illegal while locked: fault without wrap
        tbl[24] = mk(4'd6, 0, 1, 0, 6'b000000, 2, 2);
        tbl[25] = mk(4'd0, 0, 0, 0, 6'b000001, 2, 3);
        // illegal codes 6 and 15 while searching
        tbl[26] = mk(4'd6, 0, 0, 0, 6'b000000, 2, 4);
        tbl[27] = mk(4'd15, 0, 0, 0, 6'b000000, 2, 5);
        tbl[28] = mk(4'd0, 0, 0, 0, 6'b000001, 2, 6);

        reset_n  = 1'b0;
        count_in = 4'd5;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", mk(4'd5, 0, 0, 0, 6'b000000, 0, 0));

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].code);
            check($sformatf("vec%0d", i), tbl[i]);
        end

        // Relock and reach cycle_count = 3, then reset asynchronously mid-cycle.
        step(4'd1); step(4'd2); step(4'd3); step(4'd4); step(4'd5); step(4'd0);
        check("locked_cyc3", mk(4'd0, 1, 0, 1, 6'b000001, 3, 6));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", mk(4'd0, 0, 0, 0, 6'b000000, 0, 0));
        @(posedge clock);
        #1;
        check("reset_held_over_edge", mk(4'd0, 0, 0, 0, 6'b000000, 0, 0));

        // Relock from scratch after reset: no lock on 3rd edge, lock on 4th.
        step(4'd5); step(4'd0); step(4'd1);
        check("relock_not_yet", mk(4'd1, 0, 0, 0, 6'b000010, 0, 0));
        step(4'd2);
        check("relock_4th_edge", mk(4'd2, 1, 0, 0, 6'b000100, 0, 0));

        // Stuck code: fault once, then err_count climbs and saturates.
        step(4'd2);
        check("stall_fault", mk(4'd2, 0, 1, 0, 6'b000100, 0, 1));
        step(4'd2);
        check("stall_fault_clears", mk(4'd2, 0, 0, 0, 6'b000100, 0, 2));
        repeat (252) step(4'd2);
        check("err_254", mk(4'd2, 0, 0, 0, 6'b000100, 0, 254));
        step(4'd2);
        check("err_255", mk(4'd2, 0, 0, 0, 6'b000100, 0, 255));
        repeat (10) step(4'd2);
        check("err_saturated", mk(4'd2, 0, 0, 0, 6'b000100, 0, 255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
